// File: rtl/brc_burst_reader.sv
// Burst read controller: fixed-latency memory reads into a credit-limited
// return buffer, drained in address order into the downstream data FIFO.
module brc_burst_reader #(
  parameter int LEN_W  = 8,
  parameter int RD_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_addr,
  input  logic [LEN_W-1:0] req_len,
  output logic             mem_en,
  output logic [31:0]      mem_addr,
  input  logic [31:0]      mem_rdata,
  input  logic             abt_full_n,
  output logic             brc_in_valid,
  output logic [31:0]      Di,
  output logic             busy,
  output logic             done
);

  localparam int DEPTH = RD_LAT + 2;
  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH + 1);

  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW:0]   DEPTH_C  = (CW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [LEN_W-1:0] remaining;
  logic [RD_LAT-1:0] pend;
  logic [CW-1:0]    inflight;
  logic [31:0]      rbuf [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [CW:0]      credit_used;

  logic accept;
  logic wr_en;
  logic pop;
  logic last_issue;
  logic drained;

  assign accept      = req_valid && req_ready;
  assign wr_en       = pend[RD_LAT-1];
  assign pop         = brc_in_valid;
  assign last_issue  = mem_en && (remaining == LEN_W'(1));
  assign credit_used = {1'b0, inflight} + {1'b0, count};

  // Leave DRAIN on the edge that pops the last word so done follows it directly.
  assign drained = (inflight == '0) &&
                   ((count == '0) || ((count == CW'(1)) && pop));

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight = inflight + CW'(pend[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = (req_len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (last_issue) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (drained) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    mem_en    = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
      end
      RUN: begin
        mem_en = (remaining != '0) && (credit_used < DEPTH_C);
      end
      DRAIN: begin
        mem_en = 1'b0;
      end
      DONE: begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr  <= '0;
      remaining <= '0;
    end else if (accept) begin
      mem_addr  <= req_addr & ~32'd3;
      remaining <= req_len;
    end else if (mem_en) begin
      mem_addr  <= mem_addr + 32'd4;
      remaining <= remaining - LEN_W'(1);
    end
  end

  // One bit per outstanding read; the top bit marks data on mem_rdata now.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend <= '0;
    end else begin
      pend[0] <= mem_en;
      for (int i = 1; i < RD_LAT; i++) begin
        pend[i] <= pend[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      rbuf[wr_ptr] <= mem_rdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PW'(1);
      end
      unique case ({wr_en, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign brc_in_valid = (count != '0) && abt_full_n;
  assign Di           = (count != '0) ? rbuf[rd_ptr] : 32'd0;

  a_no_overflow: assert property (
    @(posedge clk) disable iff (rst)
    !(wr_en && (count == CW'(DEPTH)))
  );

endmodule

// File: tb/tb_brc_burst_reader.sv
// Scoreboard bench for brc_burst_reader: fixed-latency memory model,
// expected addresses and words queued when each command is driven.
module tb_brc_burst_reader;

  localparam int LEN_W  = 8;
  localparam int RD_LAT = 2;
  localparam int DEPTH  = RD_LAT + 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid;
  logic             req_ready;
  logic [31:0]      req_addr;
  logic [LEN_W-1:0] req_len;
  logic             mem_en;
  logic [31:0]      mem_addr;
  logic [31:0]      mem_rdata;
  logic             abt_full_n;
  logic             brc_in_valid;
  logic [31:0]      Di;
  logic             busy;
  logic             done;

  always #5 clk = ~clk;

  brc_burst_reader #(
    .LEN_W (LEN_W),
    .RD_LAT(RD_LAT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_len     (req_len),
    .mem_en      (mem_en),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .abt_full_n  (abt_full_n),
    .brc_in_valid(brc_in_valid),
    .Di          (Di),
    .busy        (busy),
    .done        (done)
  );

  int n_run  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  logic [31:0] salt = 32'h5A5A_1234;
  logic [31:0] pipe [RD_LAT];

  always @(posedge clk) begin
    pipe[0] <= mem_en ? (mem_addr ^ salt) : 32'hDEAD_BEEF;
    for (int i = 1; i < RD_LAT; i++) begin
      pipe[i] <= pipe[i-1];
    end
  end

  assign mem_rdata = pipe[RD_LAT-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int bp_lo = 1;
  int bp_hi = 0;
  always @(posedge clk) begin
    #1;
    abt_full_n = !((cyc >= bp_lo) && (cyc <= bp_hi));
  end

  logic [31:0] exp_addr_q [$];
  logic [31:0] exp_data_q [$];

  int en_cnt, push_cnt, done_cnt;
  int first_en, last_en, first_push, last_push, done_cyc, max_out;
  int acc_cyc = 0;
  int cur_len = 0;
  bit model_on = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      if (model_on && (cyc > acc_cyc) && (en_cnt < cur_len)) begin
        chk("issue_credit", 32'(mem_en), 32'((en_cnt - push_cnt) < DEPTH));
      end
      if (mem_en) begin
        chk("en_expected", 32'(exp_addr_q.size() != 0), 32'd1);
        if (exp_addr_q.size() != 0) begin
          chk("mem_addr", mem_addr, exp_addr_q.pop_front());
        end
        if (en_cnt == 0) first_en = cyc;
        last_en = cyc;
        en_cnt++;
      end
      if (brc_in_valid) begin
        chk("push_full_n", 32'(abt_full_n), 32'd1);
        chk("push_expected", 32'(exp_data_q.size() != 0), 32'd1);
        if (exp_data_q.size() != 0) begin
          chk("Di", Di, exp_data_q.pop_front());
        end
        if (push_cnt == 0) first_push = cyc;
        last_push = cyc;
        push_cnt++;
      end
      if ((en_cnt - push_cnt) > max_out) max_out = en_cnt - push_cnt;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic start_burst(input logic [31:0] a, input int len,
                             input int hold);
    logic [31:0] wa;
    wa = a & ~32'd3;
    en_cnt   = 0;
    push_cnt = 0;
    done_cnt = 0;
    max_out  = 0;
    for (int i = 0; i < len; i++) begin
      exp_addr_q.push_back(wa + 32'(4 * i));
      exp_data_q.push_back((wa + 32'(4 * i)) ^ salt);
    end
    req_addr  = a;
    req_len   = LEN_W'(len);
    req_valid = 1'b1;
    chk("req_ready", 32'(req_ready), 32'd1);
    acc_cyc  = cyc;
    cur_len  = len;
    model_on = 1'b1;
    @(posedge clk);
    #1;
    if (hold > 0) begin
      req_len = LEN_W'(5);
      repeat (hold) begin
        @(posedge clk);
        #1;
      end
    end
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while ((done_cnt == 0) && (k < budget)) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk("done_seen", 32'(done_cnt), 32'd1);
    chk("busy_at_done", 32'(busy), 32'd1);
    @(negedge clk);
    #1;
    chk("done_pulse", 32'(done_cnt), 32'd1);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_ready", 32'(req_ready), 32'd1);
    chk("sb_empty", 32'(exp_addr_q.size() + exp_data_q.size()), 32'd0);
    model_on = 1'b0;
  endtask

  task automatic chk_reset(input string pfx);
    chk({pfx, "_req_ready"}, 32'(req_ready), 32'd1);
    chk({pfx, "_mem_en"}, 32'(mem_en), 32'd0);
    chk({pfx, "_mem_addr"}, mem_addr, 32'd0);
    chk({pfx, "_push"}, 32'(brc_in_valid), 32'd0);
    chk({pfx, "_Di"}, Di, 32'd0);
    chk({pfx, "_busy"}, 32'(busy), 32'd0);
    chk({pfx, "_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_addr   = '0;
    req_len    = '0;
    abt_full_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk_reset("rst");
    rst = 1'b0;
    @(posedge clk);
    #1;

    // single word
    start_burst(32'h0000_0100, 1, 0);
    wait_done(50);
    chk("t1_en", 32'(en_cnt), 32'd1);
    chk("t1_push", 32'(push_cnt), 32'd1);
    chk("t1_first_en", 32'(first_en), 32'(acc_cyc + 1));
    chk("t1_latency", 32'(first_push - first_en), 32'(RD_LAT + 1));
    chk("t1_done", 32'(done_cyc - last_push), 32'd1);

    // streaming, with a command held high while busy
    salt = 32'h1357_9BDF;
    start_burst(32'h0000_3000, 8, 2);
    wait_done(80);
    chk("t2_en", 32'(en_cnt), 32'd8);
    chk("t2_push", 32'(push_cnt), 32'd8);
    chk("t2_first_en", 32'(first_en), 32'(acc_cyc + 1));
    chk("t2_en_span", 32'(last_en - first_en), 32'd7);
    chk("t2_push_span", 32'(last_push - first_push), 32'd7);
    chk("t2_latency", 32'(first_push - first_en), 32'(RD_LAT + 1));
    chk("t2_done", 32'(done_cyc - last_push), 32'd1);

    // backpressure for cycles 3..12 after accept
    salt  = 32'h2468_ACE0;
    bp_lo = cyc + 3;
    bp_hi = cyc + 12;
    start_burst(32'h0000_4000, 16, 0);
    wait_done(200);
    bp_lo = 1;
    bp_hi = 0;
    chk("t3_en", 32'(en_cnt), 32'd16);
    chk("t3_push", 32'(push_cnt), 32'd16);
    chk("t3_max_out", 32'(max_out), 32'(DEPTH));
    chk("t3_done", 32'(done_cyc - last_push), 32'd1);

    // zero length
    start_burst(32'h0000_0500, 0, 0);
    wait_done(10);
    chk("t4_en", 32'(en_cnt), 32'd0);
    chk("t4_push", 32'(push_cnt), 32'd0);
    chk("t4_done", 32'(done_cyc), 32'(acc_cyc + 1));

    // misaligned start near the top of the address space
    salt = 32'h0F0F_F0F0;
    start_burst(32'hFFFF_FFFE, 2, 0);
    wait_done(50);
    chk("t5_en", 32'(en_cnt), 32'd2);
    chk("t5_push", 32'(push_cnt), 32'd2);

    // reset while draining with words buffered
    salt  = 32'hCAFE_0001;
    bp_lo = cyc + 1;
    bp_hi = cyc + 1000;
    start_burst(32'h0000_6000, 4, 0);
    while (cyc < acc_cyc + 5) begin
      @(negedge clk);
      #1;
    end
    chk("t6_busy", 32'(busy), 32'd1);
    chk("t6_issued", 32'(en_cnt), 32'd4);
    chk("t6_held", 32'(en_cnt - push_cnt), 32'd4);
    rst = 1'b1;
    #1;
    chk_reset("t6_rst");
    model_on = 1'b0;
    exp_addr_q.delete();
    exp_data_q.delete();
    en_cnt   = 0;
    push_cnt = 0;
    bp_lo    = 1;
    bp_hi    = 0;
    @(negedge clk);
    #1;
    rst = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    chk("t6_quiet", 32'(en_cnt + push_cnt), 32'd0);
    salt = 32'hBEEF_0002;
    start_burst(32'h0000_7000, 2, 0);
    wait_done(50);
    chk("t6_en", 32'(en_cnt), 32'd2);
    chk("t6_push", 32'(push_cnt), 32'd2);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
